// File: rtl/data_mem_pkg.sv
// Shared encodings for the MEM-stage data memory.
//   SZ_*    : access size codes carried on the size port
//   state_t : controller states
//   CNT_W   : wait-state counter width (WAIT_CYCLES up to 15)
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering for byte/halfword/word accesses.
// Lane i always refers to byte address A+i (A = latched index).
// Ports:
//   size       : access size code
//   addr_lo    : A[1:0], used for the alignment check
//   sign_ext   : sign-extend byte/halfword loads
//   store_data : store data from the pipeline
//   raw_bytes  : mem[A+i] for i = 0..3
//   byte_en    : per-lane write enable (all zero when misaligned)
//   lane_data  : per-lane write data
//   load_data  : extended load value (zero when misaligned)
//   misalign   : misaligned address or reserved size
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic             sign_ext,
  input  logic [31:0]      store_data,
  input  logic [3:0][7:0]  raw_bytes,
  output logic [3:0]       byte_en,
  output logic [3:0][7:0]  lane_data,
  output logic [31:0]      load_data,
  output logic             misalign
);

  always_comb begin
    case (size)
      SZ_WORD: misalign = (addr_lo != 2'b00);
      SZ_HALF: misalign = addr_lo[0];
      SZ_BYTE: misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_en   = 4'b0000;
    lane_data = '0;
    load_data = '0;
    if (!misalign) begin
      case (size)
        SZ_WORD: begin
          byte_en      = 4'b1111;
          lane_data[0] = store_data[31:24];
          lane_data[1] = store_data[23:16];
          lane_data[2] = store_data[15:8];
          lane_data[3] = store_data[7:0];
          load_data    = {raw_bytes[0], raw_bytes[1], raw_bytes[2], raw_bytes[3]};
        end
        SZ_HALF: begin
          byte_en      = 4'b0011;
          lane_data[0] = store_data[15:8];
          lane_data[1] = store_data[7:0];
          load_data    = {{16{sign_ext & raw_bytes[0][7]}}, raw_bytes[0], raw_bytes[1]};
        end
        SZ_BYTE: begin
          byte_en      = 4'b0001;
          lane_data[0] = store_data[7:0];
          load_data    = {{24{sign_ext & raw_bytes[0][7]}}, raw_bytes[0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_ws.sv
// Byte-addressable big-endian data memory with request/ready handshake
// and a fixed number of wait states per access.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   mem_r_en, mem_w_en : held requests (write wins when both set)
//   address            : byte address, wraps modulo DEPTH_BYTES
//   dataToWrite        : store data
//   size, sign_ext     : access size and load extension
//   result             : load data while ready on a read, else 0
//   ready              : one-cycle completion pulse
//   busy               : transaction in flight
//   align_err          : misaligned/reserved access, with ready
//
// state  | meaning
// IDLE   | waiting for a request; latches it on acceptance
// WAIT   | counting down wait states
// ACCESS | array access performed, ready pulses
module data_memory_ws
  import data_mem_pkg::*;
#(
  parameter  int DEPTH_BYTES = 256,
  parameter  int WAIT_CYCLES = 2,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] dataToWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result,
  output logic        ready,
  output logic        busy,
  output logic        align_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [AW-1:0]      addr_q;
  logic [31:0]        data_q;
  logic [1:0]         size_q;
  logic               sext_q;
  logic               wr_q;
  logic               req;
  logic               in_access;

  logic [7:0]         mem [DEPTH_BYTES];
  logic [AW-1:0]      idx [4];
  logic [3:0][7:0]    raw_bytes;
  logic [3:0]         byte_en;
  logic [3:0][7:0]    lane_data;
  logic [31:0]        load_data;
  logic               misalign;

  // Upper address bits are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW];

  assign req = mem_w_en | mem_r_en;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && req) begin
      cnt_q <= WAIT_INIT;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && req) begin
      addr_q <= address[AW-1:0];
      data_q <= dataToWrite;
      size_q <= size;
      sext_q <= sign_ext;
      wr_q   <= mem_w_en;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i]       = addr_q + AW'(i);
      raw_bytes[i] = mem[idx[i]];
    end
  end

  mem_lane_align u_lane (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sign_ext   (sext_q),
    .store_data (data_q),
    .raw_bytes  (raw_bytes),
    .byte_en    (byte_en),
    .lane_data  (lane_data),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  // Commit happens on the edge leaving ACCESS; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx[i]] <= lane_data[i];
      end
    end
  end

  // Reset masks the completion outputs so an aborted access never reports.
  assign in_access = (state_q == ACCESS) && !rst;

  always_comb begin
    ready     = in_access;
    busy      = (state_q == WAIT) || (state_q == ACCESS);
    align_err = in_access && misalign;
    result    = (in_access && !wr_q) ? load_data : 32'h0;
  end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
Parametrised, byte-addressable, big-endian data memory for the MEM stage. It supports byte, halfword and word accesses, with optional sign extension on loads. Each access runs through a request/ready handshake with a configurable number of wait states. The pipeline stalls on busy and resumes when ready pulses.

Parameters:
DEPTH_BYTES, 256, memory size in bytes; power of two, at least 4.
WAIT_CYCLES, 2, extra wait states per access (0..15).
AW, $clog2(DEPTH_BYTES), derived byte-index width; not overridden.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
mem_r_en  in  1  read request; held until ready.
mem_w_en  in  1  write request; held until ready; has priority over mem_r_en.
address  in  32  byte address; bits [31:AW] ignored, so accesses wrap.
dataToWrite  in  32  store data; byte uses [7:0], halfword uses [15:0].
size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
sign_ext  in  1  sign-extend byte/halfword loads.
result  out  32  load data, valid only while ready=1 for a read; 0 otherwise.
ready  out  1  one-cycle completion pulse.
busy  out  1  transaction in flight (WAIT or ACCESS state).
align_err  out  1  asserted together with ready when the access was misaligned or used the reserved size.

Behaviour:
- Reset:
  - state=IDLE, counter=0; result, ready, busy and align_err all 0.
  - Any in-flight transaction is dropped and no write occurs.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - On an edge where mem_w_en or mem_r_en is 1, latch address[AW-1:0], dataToWrite, size, sign_ext and op (write if mem_w_en).
  - Load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT: counter decrements each cycle. When counter==1 at an edge, go to ACCESS.
- ACCESS:
  - Perform the access on the latched values. ready=1 for exactly this cycle, then return to IDLE.
  - Write: memory is updated at the edge leaving ACCESS.
  - Read: result is driven combinationally from the array during ACCESS.
- Latency: ready is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- busy=1 in WAIT and ACCESS.
- Request inputs are ignored outside IDLE. Changing them mid-transaction has no effect.
- The master deasserts its enables on the cycle after ready. Enables still high in the following IDLE cycle start a new transaction.
- Byte layout is big-endian, with A = latched index:
  - Word: mem[A]=d[31:24], mem[A+1]=d[23:16], mem[A+2]=d[15:8], mem[A+3]=d[7:0].
  - Halfword: mem[A]=d[15:8], mem[A+1]=d[7:0].
  - Byte: mem[A]=d[7:0].
- Load extension: byte and halfword loads are zero-extended, or sign-extended when the latched sign_ext=1.
- Alignment rules:
  - Word requires A[1:0]=00; halfword requires A[0]=0.
  - A violation, or size=11, still runs the full latency.
  - On a violation: no memory write, result=0, align_err=1 with ready.
- Wrap: index arithmetic is mod DEPTH_BYTES. An aligned access never straddles the top of memory.
- Simultaneous mem_w_en and mem_r_en: treated as a write only.
- Reset asserted in WAIT or ACCESS: the next state is IDLE, no write is committed, and ready stays 0.

Decomposition:
- Package data_mem_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The FSM state enum {IDLE, WAIT, ACCESS}.
  - The counter width constant (4).
- One combinational sub-module, mem_lane_align:
  - Inputs: size, A[1:0], sign_ext, raw bytes.
  - Outputs: per-byte write enables, write-lane data, extended load value and the misalign flag.
- The FSM, counter and array stay in the top module.

Test Plan:
- Word round-trip, WAIT_CYCLES=2: write 0xDEADBEEF at 0x10 → ready on cycle 3 after acceptance, busy high cycles 1-3. Read 0x10 → result=0xDEADBEEF with ready. Byte read 0x10 → 0x000000DE.
- Halfword and byte sign extension:
  - Write 0x12348081 at 0x20, then halfword read 0x22 with sign_ext=1 → 0xFFFF8081; with sign_ext=0 → 0x00008081.
  - Byte read 0x21 with sign_ext=1 → 0x00000034.
- Sub-word stores: word 0 at 0x30, byte store 0xA5 at 0x33, halfword store 0xBEEF at 0x30 → word read 0x30 = 0xBEEF00A5.
- Misalignment:
  - Word write at 0x41 → align_err=1 with ready, and a word read at 0x40 is unchanged.
  - Halfword read at 0x43 → result=0, align_err=1.
  - size=11 → align_err=1.
- Wrap and WAIT_CYCLES=0: word write 0x11223344 at 0x1FC → read at 0xFC returns 0x11223344. Ready arrives 1 cycle after acceptance.
- Reset mid-WAIT: start write 0xCAFEF00D at 0x50 (previously 0), assert rst in the WAIT cycle → ready never pulses and a read of 0x50 returns 0.
